// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Holds the FSM state encoding and the width helpers used to size ports and counters.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Ceiling log2; returns 0 for inputs of 0 or 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Beat counter width for a given burst length.
   function automatic int unsigned bcw(input int unsigned burst);
      return clog2(burst) + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from ptr+1 with wrap.
// Purely combinational.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   // Two passes: indices above ptr first, then the wrapped range 0..ptr.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!found && req[i] && (IDW'(i) > ptr)) begin
            found = 1'b1;
            idx   = IDW'(i);
         end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!found && req[i] && (IDW'(i) <= ptr)) begin
            found = 1'b1;
            idx   = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: round-robin grants of up to BURST words
// from NREQ producers onto the single winc/wdata port, back-pressured by wfull.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned DSIZE = 8,
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned BURST = 4,
   localparam int unsigned IDW   = clog2(NREQ)
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy
);

   localparam int unsigned BCW = bcw(BURST);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDW-1:0]   grant_nxt;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   ptr_nxt;
   logic [BCW-1:0]   beat;
   logic [BCW-1:0]   beat_nxt;

   logic             pick_found;
   logic [IDW-1:0]   pick_idx;
   logic             valid_g;
   logic [DSIZE-1:0] data_g;
   logic             xfer;
   logic             last_beat;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Select the granted requester's valid and data; other requesters are never looked at.
   always_comb begin
      valid_g = 1'b0;
      data_g  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (IDW'(i) == grant_id) begin
            valid_g = req_valid[i];
            data_g  = req_data[i*DSIZE +: DSIZE];
         end
      end
   end

   assign xfer      = valid_g & ~wfull;
   assign last_beat = (beat == BCW'(BURST - 1));

   // State register with grant index, round-robin pointer and beat count.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         state    <= IDLE;
         grant_id <= '0;
         ptr      <= IDW'(NREQ - 1);
         beat     <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         ptr      <= ptr_nxt;
         beat     <= beat_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      ptr_nxt   = ptr;
      beat_nxt  = beat;
      unique case (state)
         IDLE: begin
            beat_nxt = '0;
            if (pick_found) begin
               grant_nxt = pick_idx;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!valid_g) begin
               state_nxt = IDLE;
               ptr_nxt   = grant_id;
               beat_nxt  = '0;
            end else if (xfer) begin
               if (last_beat) begin
                  state_nxt = IDLE;
                  ptr_nxt   = grant_id;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt  = beat + BCW'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Write port and handshakes; winc follows the registered wfull so no write lands on a full FIFO.
   always_comb begin
      winc      = 1'b0;
      busy      = 1'b0;
      req_ready = '0;
      wdata     = data_g;
      if (state == GRANT) begin
         busy = 1'b1;
         winc = xfer;
         for (int i = 0; i < int'(NREQ); i++) begin
            if (IDW'(i) == grant_id) begin
               req_ready[i] = ~wfull;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (DSIZE=8, NREQ=4, BURST=4).
module tb_fifo_wr_arbiter;

   logic        wclk;
   logic        wrst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        wfull;
   logic        winc;
   logic [7:0]  wdata;
   logic [1:0]  grant_id;
   logic        busy;

   int tests;
   int fails;

   fifo_wr_arbiter #(
      .DSIZE (8),
      .NREQ  (4),
      .BURST (4)
   ) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic next();
      @(posedge wclk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [7:0] d);
      req_data[i*8 +: 8] = d;
   endtask

   task automatic do_reset();
      wrst_n    = 1'b0;
      req_valid = 4'b0000;
      wfull     = 1'b0;
      req_data  = '0;
      next();
      next();
      wrst_n = 1'b1;
   endtask

   task automatic test_reset();
      wrst_n    = 1'b0;
      req_valid = 4'b1111;
      wfull     = 1'b0;
      req_data  = 32'h33221100;
      next();
      for (int k = 0; k < 2; k++) begin
         @(negedge wclk);
         tests++;
         if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs: winc=%b ready=%b busy=%b grant=%0d, required 0 0000 0 0",
                     winc, req_ready, busy, grant_id);
         end
         next();
      end
      wrst_n = 1'b1;
      @(negedge wclk);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle_busy: busy=%b, required 0", busy);
      end
      next();
      @(negedge wclk);
      tests++;
      if (grant_id !== 2'd0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL reset_first_grant: grant=%0d busy=%b, required 0 1", grant_id, busy);
      end
      req_valid = 4'b0000;
      next();
      next();
   endtask

   task automatic test_lone_requester();
      logic [14:0] pat;
      int p;
      int e;
      logic xf;
      pat = 15'b001101111011110;
      p = 0;
      e = 0;
      do_reset();
      for (int c = 0; c < 15; c++) begin
         req_valid = (p < 10) ? 4'b0100 : 4'b0000;
         set_data(2, 8'(8'h10 + p));
         @(negedge wclk);
         tests++;
         if (winc !== pat[c]) begin
            fails++;
            $display("FAIL lone_winc c=%0d: winc=%b, required %b", c, winc, pat[c]);
         end
         if (winc === 1'b1) begin
            tests++;
            if (wdata !== 8'(8'h10 + e)) begin
               fails++;
               $display("FAIL lone_wdata c=%0d: wdata=%h, required %h", c, wdata, 8'(8'h10 + e));
            end
            e++;
         end
         if (c == 1) begin
            tests++;
            if (grant_id !== 2'd2) begin
               fails++;
               $display("FAIL lone_grant: grant=%0d, required 2", grant_id);
            end
         end
         xf = req_valid[2] & req_ready[2];
         next();
         if (xf) p++;
      end
      tests++;
      if (e != 10) begin
         fails++;
         $display("FAIL lone_count: writes=%0d, required 10", e);
      end
   endtask

   task automatic test_round_robin();
      logic ew;
      int g;
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'hA0 + i));
      for (int c = 0; c < 25; c++) begin
         @(negedge wclk);
         ew = (c % 5) != 0;
         g  = (c / 5) % 4;
         tests++;
         if (winc !== ew) begin
            fails++;
            $display("FAIL rr_winc c=%0d: winc=%b, required %b", c, winc, ew);
         end
         if (ew) begin
            tests++;
            if (grant_id !== 2'(g) || wdata !== 8'(8'hA0 + g) || req_ready !== 4'(1 << g)) begin
               fails++;
               $display("FAIL rr_grant c=%0d: grant=%0d wdata=%h ready=%b, required %0d %h %b",
                        c, grant_id, wdata, req_ready, g, 8'(8'hA0 + g), 4'(1 << g));
            end
         end
         next();
      end
      req_valid = 4'b0000;
      next();
      next();
   endtask

   task automatic test_back_pressure();
      int n;
      int w;
      logic ew;
      logic eb;
      logic xf;
      n = 0;
      w = 0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         wfull     = (c >= 3 && c <= 5);
         req_valid = (n < 4) ? 4'b0010 : 4'b0000;
         set_data(1, 8'(8'h40 + n));
         @(negedge wclk);
         ew = (c == 1 || c == 2 || c == 6 || c == 7);
         eb = (c >= 1 && c <= 7);
         tests++;
         if (winc !== ew || busy !== eb) begin
            fails++;
            $display("FAIL bp_winc_busy c=%0d: winc=%b busy=%b, required %b %b", c, winc, busy, ew, eb);
         end
         if (winc === 1'b1) begin
            tests++;
            if (wdata !== 8'(8'h40 + w)) begin
               fails++;
               $display("FAIL bp_wdata c=%0d: wdata=%h, required %h", c, wdata, 8'(8'h40 + w));
            end
            w++;
         end
         if (wfull) begin
            tests++;
            if (req_ready !== 4'b0000 || grant_id !== 2'd1) begin
               fails++;
               $display("FAIL bp_stall c=%0d: ready=%b grant=%0d, required 0000 1", c, req_ready, grant_id);
            end
         end
         xf = req_valid[1] & req_ready[1];
         next();
         if (xf) n++;
      end
      wfull = 1'b0;
      tests++;
      if (w != 4) begin
         fails++;
         $display("FAIL bp_count: writes=%0d, required 4", w);
      end
   endtask

   task automatic test_early_release();
      logic ew;
      logic eb;
      int b0;
      b0 = 0;
      do_reset();
      set_data(0, 8'h50);
      set_data(3, 8'h53);
      for (int c = 0; c < 10; c++) begin
         req_valid = (c == 0) ? 4'b1000 : (c == 1) ? 4'b1001 : (c == 2) ? 4'b0001 : 4'b1001;
         @(negedge wclk);
         ew = (c == 1 || (c >= 4 && c <= 7) || c == 9);
         eb = (c == 1 || c == 2 || (c >= 4 && c <= 7) || c == 9);
         tests++;
         if (winc !== ew || busy !== eb) begin
            fails++;
            $display("FAIL er_winc_busy c=%0d: winc=%b busy=%b, required %b %b", c, winc, busy, ew, eb);
         end
         if (c == 1 || c == 4 || c == 9) begin
            tests++;
            if (grant_id !== ((c == 4) ? 2'd0 : 2'd3)) begin
               fails++;
               $display("FAIL er_grant c=%0d: grant=%0d, required %0d", c, grant_id, (c == 4) ? 0 : 3);
            end
         end
         if (winc === 1'b1 && grant_id === 2'd0) b0++;
         next();
      end
      req_valid = 4'b0000;
      tests++;
      if (b0 != 4) begin
         fails++;
         $display("FAIL er_beats: requester0 writes=%0d, required 4", b0);
      end
      next();
      next();
   endtask

   task automatic test_reset_mid_burst();
      logic ew;
      logic eb;
      do_reset();
      set_data(0, 8'h70);
      set_data(2, 8'h60);
      for (int c = 0; c < 7; c++) begin
         wrst_n    = !(c == 3 || c == 4);
         req_valid = (c < 5) ? 4'b0100 : 4'b0101;
         @(negedge wclk);
         ew = (c >= 1 && c <= 3) || c == 6;
         eb = ew;
         tests++;
         if (winc !== ew || busy !== eb) begin
            fails++;
            $display("FAIL mr_winc_busy c=%0d: winc=%b busy=%b, required %b %b", c, winc, busy, ew, eb);
         end
         if (c == 4) begin
            tests++;
            if (grant_id !== 2'd0 || req_ready !== 4'b0000) begin
               fails++;
               $display("FAIL mr_reset_state: grant=%0d ready=%b, required 0 0000", grant_id, req_ready);
            end
         end
         if (c == 6) begin
            tests++;
            if (grant_id !== 2'd0 || wdata !== 8'h70) begin
               fails++;
               $display("FAIL mr_regrant: grant=%0d wdata=%h, required 0 70", grant_id, wdata);
            end
         end
         next();
      end
      req_valid = 4'b0000;
      wrst_n    = 1'b1;
      next();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_lone_requester();
      test_round_robin();
      test_back_pressure();
      test_early_release();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
